// File: rtl/jtag_dmi_master.sv
// DTM-side DMI initiator: issues captured scan words to the DM and returns responses with sticky dmistat.
// Optional per-transaction timeout is compiled in with `define DMI_TIMEOUT_EN.
module jtag_dmi_master #(
    parameter int unsigned DMI_ADDR_BITS  = 6,
    parameter int unsigned DMI_DATA_BITS  = 32,
    parameter int unsigned DMI_OP_BITS    = 2
`ifdef DMI_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               scan_req_valid,
    input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] scan_req_data,
    output logic                                               scan_resp_valid,
    output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] scan_resp_data,
    input  logic                                               dmi_reset,
    input  logic                                               dmi_hard_reset,
    output logic [1:0]                                         dmi_stat,
    output logic                                               dtm_req_valid,
    output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data,
    input  logic                                               dm_is_busy,
    input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data
);

    localparam int unsigned DMI_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_RESP = 2'd3;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    logic [1:0]          state, state_n;
    logic                req_valid_n;
    logic [DMI_BITS-1:0] req_data_n;
    logic                resp_valid_n;
    logic [DMI_BITS-1:0] resp_data_n;
    logic [1:0]          stat_n;

    // Status-only response word: address echoed, data zeroed.
    function automatic logic [DMI_BITS-1:0] status_word(
        input logic [DMI_ADDR_BITS-1:0] addr,
        input logic [1:0]               st
    );
        return {addr, {DMI_DATA_BITS{1'b0}}, DMI_OP_BITS'(st)};
    endfunction

`ifdef DMI_TIMEOUT_EN
    localparam int unsigned TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0]  ST_FAILED   = 2'd2;

    logic [TIMER_W-1:0] timer, timer_n;
    logic               timeout_c;

    // Fires on the edge that completes TIMEOUT_CYCLES cycles outside IDLE.
    assign timeout_c = (state != S_IDLE) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        req_valid_n  = 1'b0;
        req_data_n   = dtm_req_data;
        resp_valid_n = 1'b0;
        resp_data_n  = scan_resp_data;
        stat_n       = dmi_stat;

        case (state)
            S_IDLE: begin
                if (scan_req_valid) begin
                    if (dmi_stat == ST_OK) begin
                        req_valid_n = 1'b1;
                        req_data_n  = scan_req_data;
                        state_n     = S_ISSUE;
                    end else begin
                        resp_valid_n = 1'b1;
                        resp_data_n  = status_word(scan_req_data[DMI_BITS-1 -: DMI_ADDR_BITS], dmi_stat);
                    end
                end
            end
            S_ISSUE: state_n = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (dm_is_busy) begin
                    state_n = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (!dm_is_busy) begin
                    resp_valid_n = 1'b1;
                    resp_data_n  = dm_resp_data;
                    state_n      = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A scan arriving while a transaction is in flight is dropped.
        if (scan_req_valid && (state != S_IDLE) && (dmi_stat == ST_OK)) begin
            stat_n = ST_BUSY;
        end

`ifdef DMI_TIMEOUT_EN
        if (timeout_c && (state_n != S_IDLE)) begin
            state_n      = S_IDLE;
            resp_valid_n = 1'b1;
            resp_data_n  = status_word(dtm_req_data[DMI_BITS-1 -: DMI_ADDR_BITS], ST_FAILED);
            if (dmi_stat == ST_OK) begin
                stat_n = ST_FAILED;
            end
        end
        if ((state == S_IDLE) || (state_n == S_IDLE)) begin
            timer_n = '0;
        end else if (timer != TIMER_W'(TIMEOUT_CYCLES)) begin
            timer_n = timer + TIMER_W'(1);
        end else begin
            timer_n = timer;
        end
`endif

        if (dmi_reset) begin
            stat_n = ST_OK;
        end

        // Hard reset abandons everything, including a scan in the same cycle.
        if (dmi_hard_reset) begin
            state_n      = S_IDLE;
            req_valid_n  = 1'b0;
            req_data_n   = dtm_req_data;
            resp_valid_n = 1'b0;
            resp_data_n  = scan_resp_data;
            stat_n       = ST_OK;
`ifdef DMI_TIMEOUT_EN
            timer_n      = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            dtm_req_valid   <= 1'b0;
            dtm_req_data    <= '0;
            scan_resp_valid <= 1'b0;
            scan_resp_data  <= '0;
            dmi_stat        <= ST_OK;
        end else begin
            state           <= state_n;
            dtm_req_valid   <= req_valid_n;
            dtm_req_data    <= req_data_n;
            scan_resp_valid <= resp_valid_n;
            scan_resp_data  <= resp_data_n;
            dmi_stat        <= stat_n;
        end
    end

`ifdef DMI_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else begin
            timer <= timer_n;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Scoreboard bench for jtag_dmi_master with a small behavioural DM responder.
module tb_jtag_dmi_master;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_req_valid = 1'b0;
    logic [39:0] scan_req_data = '0;
    logic        scan_resp_valid;
    logic [39:0] scan_resp_data;
    logic        dmi_reset = 1'b0;
    logic        dmi_hard_reset = 1'b0;
    logic [1:0]  dmi_stat;
    logic        dtm_req_valid;
    logic [39:0] dtm_req_data;
    logic        dm_is_busy = 1'b0;
    logic [39:0] dm_resp_data = '0;

    jtag_dmi_master dut (
        .clk            (clk),
        .rst            (rst),
        .scan_req_valid (scan_req_valid),
        .scan_req_data  (scan_req_data),
        .scan_resp_valid(scan_resp_valid),
        .scan_resp_data (scan_resp_data),
        .dmi_reset      (dmi_reset),
        .dmi_hard_reset (dmi_hard_reset),
        .dmi_stat       (dmi_stat),
        .dtm_req_valid  (dtm_req_valid),
        .dtm_req_data   (dtm_req_data),
        .dm_is_busy     (dm_is_busy),
        .dm_resp_data   (dm_resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [39:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // DM responder: busy for dm_lat cycles after accepting a strobe, or until dm_hold drops.
    int          dm_lat  = 1;
    bit          dm_hold = 1'b0;
    logic [31:0] dm_rd_val = '0;
    int          dm_cnt = 0;
    logic [39:0] dm_word = '0;
    always @(posedge clk) begin
        if (!dm_is_busy) begin
            if (dtm_req_valid) begin
                dm_is_busy <= 1'b1;
                dm_cnt     <= dm_lat;
                dm_word    <= dtm_req_data;
            end
        end else if (!dm_hold) begin
            if (dm_cnt <= 1) begin
                dm_is_busy   <= 1'b0;
                dm_resp_data <= {dm_word[39:34], (dm_word[1:0] == 2'd1) ? dm_rd_val : 32'h0, 2'b00};
            end else begin
                dm_cnt <= dm_cnt - 1;
            end
        end
    end

    // Monitor: responses against scoreboard, strobe shape and count.
    int   strobes  = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (scan_resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'(scan_resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_data", 64'(scan_resp_data), 64'(e.data));
                    if (e.due >= 0) check("resp_cycle", 64'(cyc), 64'(e.due));
                end
            end
            if (dtm_req_valid) begin
                strobes++;
                check("req_single_pulse", 64'(prev_req), 64'd0);
            end
        end
        prev_req = dtm_req_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one scan word for one cycle; push expectation when lat >= 0.
    task automatic send(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                        input logic [39:0] exp, input int lat);
        exp_t e;
        if (lat >= 0) begin
            e.data = exp;
            e.due  = cyc + lat;
            sb.push_back(e);
        end
        scan_req_valid = 1'b1;
        scan_req_data  = {a, d, op};
        step(1);
        scan_req_valid = 1'b0;
    endtask

    task automatic wait_dm_idle();
        int n = 0;
        while (dm_is_busy && n < 200) begin
            step(1);
            n++;
        end
        if (dm_is_busy) check("dm_idle_timeout", 64'd1, 64'd0);
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1);
        check("rst_req_valid", 64'(dtm_req_valid), 64'd0);
        check("rst_req_data", 64'(dtm_req_data), 64'd0);
        check("rst_resp_valid", 64'(scan_resp_valid), 64'd0);
        check("rst_resp_data", 64'(scan_resp_data), 64'd0);
        check("rst_stat", 64'(dmi_stat), 64'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // Write
        send(6'h04, 32'hDEADBEEF, 2'd2, {6'h04, 32'h0, 2'd0}, 4);
        step(6);
        check("write_strobes", 64'(strobes), 64'd1);
        check("write_req_data", 64'(dtm_req_data), 64'({6'h04, 32'hDEADBEEF, 2'd2}));
        check("write_stat", 64'(dmi_stat), 64'd0);

        // Read
        dm_rd_val = 32'h00400982;
        send(6'h11, 32'h0, 2'd1, {6'h11, 32'h00400982, 2'd0}, 4);
        step(6);
        check("read_strobes", 64'(strobes), 64'd2);

        // Overlap sets sticky busy; first completes normally
        send(6'h05, 32'h12345678, 2'd2, {6'h05, 32'h0, 2'd0}, 4);
        send(6'h06, 32'h0000_0001, 2'd2, '0, -1);
        check("overlap_stat", 64'(dmi_stat), 64'd3);
        step(6);
        check("overlap_strobes", 64'(strobes), 64'd3);
        send(6'h07, 32'h0000_00AA, 2'd1, {6'h07, 32'h0, 2'd3}, 1);
        step(3);
        check("busy_reject_strobes", 64'(strobes), 64'd3);
        check("busy_reject_stat", 64'(dmi_stat), 64'd3);
        dmi_reset = 1'b1;
        step(1);
        dmi_reset = 1'b0;
        check("dmi_reset_stat", 64'(dmi_stat), 64'd0);
        send(6'h08, 32'h0000_0055, 2'd2, {6'h08, 32'h0, 2'd0}, 4);
        step(6);
        check("after_reset_strobes", 64'(strobes), 64'd4);

        // dmi_reset coincident with the overlap that would set busy
        send(6'h09, 32'h0BAD_F00D, 2'd2, {6'h09, 32'h0, 2'd0}, 4);
        scan_req_valid = 1'b1;
        scan_req_data  = {6'h0C, 32'h0, 2'd1};
        dmi_reset      = 1'b1;
        step(1);
        scan_req_valid = 1'b0;
        dmi_reset      = 1'b0;
        check("clear_wins_stat", 64'(dmi_stat), 64'd0);
        step(6);
        check("clear_wins_strobes", 64'(strobes), 64'd5);

        // Hard reset while waiting for the response
        dm_lat = 5;
        send(6'h0A, 32'h1111_2222, 2'd2, '0, -1);
        send(6'h0D, 32'h0, 2'd1, '0, -1);
        step(2);
        check("pre_hard_stat", 64'(dmi_stat), 64'd3);
        dmi_hard_reset = 1'b1;
        step(1);
        dmi_hard_reset = 1'b0;
        check("hard_stat", 64'(dmi_stat), 64'd0);
        check("hard_req_valid", 64'(dtm_req_valid), 64'd0);
        wait_dm_idle();
        dm_lat = 1;
        send(6'h0E, 32'h3333_4444, 2'd2, {6'h0E, 32'h0, 2'd0}, 4);
        step(6);
        check("post_hard_strobes", 64'(strobes), 64'd7);

        // Hard reset coincident with a scan in IDLE: word dropped
        scan_req_valid = 1'b1;
        scan_req_data  = {6'h0F, 32'h5, 2'd2};
        dmi_hard_reset = 1'b1;
        step(1);
        scan_req_valid = 1'b0;
        dmi_hard_reset = 1'b0;
        step(4);
        check("hard_drop_strobes", 64'(strobes), 64'd7);
        check("hard_drop_stat", 64'(dmi_stat), 64'd0);

        // rst mid-transaction
        send(6'h10, 32'h7777_8888, 2'd2, '0, -1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_mid_req_valid", 64'(dtm_req_valid), 64'd0);
        check("rst_mid_req_data", 64'(dtm_req_data), 64'd0);
        check("rst_mid_resp_data", 64'(scan_resp_data), 64'd0);
        check("rst_mid_stat", 64'(dmi_stat), 64'd0);
        wait_dm_idle();
        send(6'h12, 32'h0, 2'd2, {6'h12, 32'h0, 2'd0}, 4);
        step(6);

`ifdef DMI_TIMEOUT_EN
        // DM stuck busy: timeout response TIMEOUT cycles after ISSUE entry
        dm_hold = 1'b1;
        send(6'h13, 32'h0, 2'd1, {6'h13, 32'h0, 2'd2}, TIMEOUT + 1);
        step(TIMEOUT + 2);
        check("timeout_stat", 64'(dmi_stat), 64'd2);
        dm_hold = 1'b0;
        wait_dm_idle();
        dmi_reset = 1'b1;
        step(1);
        dmi_reset = 1'b0;
        check("timeout_clear_stat", 64'(dmi_stat), 64'd0);
`endif

        step(4);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
